// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for the single-port data memory.
// Bounded bursts, legality check, and a registered one-cycle response.
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 1017,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [31:0]       r0_wdata,
   output logic              r0_rvalid,
   output logic [31:0]       r0_rdata,
   output logic              r0_err,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [31:0]       r1_wdata,
   output logic              r1_rvalid,
   output logic [31:0]       r1_rdata,
   output logic              r1_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_BYTES - 4);

   logic          owner;
   logic [CW-1:0] burst_cnt;
   logic          v_own;
   logic          v_oth;
   logic          g_own;
   logic          g_oth;
   logic          gnt0;
   logic          gnt1;
   logic          any_gnt;
   logic          sel_we;
   logic          legal;
   logic [31:0]   rsp_data;

   // Grant selection, memory port mux and legality check
   always_comb begin
      v_own    = owner ? r1_valid : r0_valid;
      v_oth    = owner ? r0_valid : r1_valid;
      g_own    = v_own & (~v_oth | (burst_cnt < MAXB));
      g_oth    = ~g_own & v_oth;
      gnt0     = ~rst & (owner ? g_oth : g_own);
      gnt1     = ~rst & (owner ? g_own : g_oth);
      any_gnt  = gnt0 | gnt1;
      r0_ready = gnt0;
      r1_ready = gnt1;
      mem_addr  = gnt1 ? r1_addr  : r0_addr;
      mem_wdata = gnt1 ? r1_wdata : r0_wdata;
      sel_we    = gnt1 ? r1_we    : r0_we;
      legal     = (mem_addr[1:0] == 2'b00) & (mem_addr <= LAST);
      mem_we    = any_gnt & sel_we & legal;
      rsp_data  = (~sel_we & legal) ? mem_rdata : 32'd0;
   end

   // Ownership/burst tracking and per-requester response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= 1'b0;
         burst_cnt <= '0;
         r0_rvalid <= 1'b0;
         r0_rdata  <= '0;
         r0_err    <= 1'b0;
         r1_rvalid <= 1'b0;
         r1_rdata  <= '0;
         r1_err    <= 1'b0;
      end else begin
         if (!any_gnt) begin
            burst_cnt <= '0;
         end else if (gnt1 == owner) begin
            if (burst_cnt != MAXB)
               burst_cnt <= burst_cnt + CW'(1);
         end else begin
            owner     <= gnt1;
            burst_cnt <= CW'(1);
         end
         r0_rvalid <= gnt0;
         r0_err    <= gnt0 & ~legal;
         if (gnt0)
            r0_rdata <= rsp_data;
         r1_rvalid <= gnt1;
         r1_err    <= gnt1 & ~legal;
         if (gnt1)
            r1_rdata <= rsp_data;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences,
// and random traffic against a rule-level reference model.
module tb_dmem_arbiter;

   localparam int MB   = 1017;
   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic        r0_valid, r0_ready, r0_we, r0_rvalid, r0_err;
   logic [31:0] r0_addr, r0_wdata, r0_rdata;
   logic        r1_valid, r1_ready, r1_we, r1_rvalid, r1_err;
   logic [31:0] r1_addr, r1_wdata, r1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   logic [7:0] mem  [MB];
   logic [7:0] refm [MB];

   int vec = 0;
   int bad = 0;

   typedef struct packed {
      logic        rst;
      logic        v0;
      logic        w0;
      logic [31:0] a0;
      logic [31:0] d0;
      logic        v1;
      logic        w1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic        rdy0;
      logic        rdy1;
      logic        mwe;
      logic        rv0;
      logic        rv1;
      logic        er0;
      logic        er1;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic        chk;
   } vec_t;

   vec_t tbl [15];

   dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(MB), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we),
      .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid),
      .r0_rdata(r0_rdata), .r0_err(r0_err),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we),
      .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid),
      .r1_rdata(r1_rdata), .r1_err(r1_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input int i);
      return 8'(i * 37 + 11);
   endfunction

   function automatic logic [31:0] init_word(input int a);
      return {init_byte(a + 3), init_byte(a + 2),
              init_byte(a + 1), init_byte(a)};
   endfunction

   // Memory model: combinational little-endian read
   always_comb begin
      mem_rdata = '0;
      for (int k = 0; k < 4; k++)
         if (mem_addr < 32'(MB - k))
            mem_rdata[8*k +: 8] = mem[mem_addr + 32'(k)];
   end

   // Memory model: preload, then synchronous 4-byte write
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < MB; i++)
            mem[i] <= init_byte(i);
      end else if (mem_we) begin
         for (int k = 0; k < 4; k++)
            mem[mem_addr + 32'(k)] <= mem_wdata[8*k +: 8];
      end
   end

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] w;
      for (int k = 0; k < 4; k++)
         w[8*k +: 8] = refm[a + 32'(k)];
      return w;
   endfunction

   task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
      for (int k = 0; k < 4; k++)
         refm[a + 32'(k)] = d[8*k +: 8];
   endtask

   function automatic bit is_legal(input logic [31:0] a);
      return (a % 4 == 0) && (a <= 32'(MB - 4));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic r,
                        input logic v0, input logic w0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic v1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1);
      @(negedge clk);
      rst      = r;
      r0_valid = v0;
      r0_we    = w0;
      r0_addr  = a0;
      r0_wdata = d0;
      r1_valid = v1;
      r1_we    = w1;
      r1_addr  = a1;
      r1_wdata = d1;
      #1;
   endtask

   task automatic do_reset();
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom % 6)
         0: return 32'h20;
         1: return 32'h24;
         2: return 32'(($urandom % 254) * 4);
         3: return 32'd1012;
         4: return ($urandom % 2) ? 32'd1016 : 32'd1014;
         default: return $urandom;
      endcase
   endfunction

   int          seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
   logic [31:0] w3f4;
   bit          pv [2];
   bit          pw [2];
   logic [31:0] pa [2];
   logic [31:0] pd [2];
   bit          e_rv [2];
   bit          e_er [2];
   logic [31:0] e_rd [2];
   int          m_owner, m_cnt, g;
   bit          rr, lg;
   logic [31:0] ea, ed;

   initial begin
      load = 1'b1;
      rst = 1'b1;
      r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
      r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
      for (int i = 0; i < MB; i++)
         refm[i] = init_byte(i);
      w3f4 = init_word('h3F4);
      @(posedge clk);
      #1 load = 1'b0;

      tbl[0]  = '{1, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0, 0};
      tbl[1]  = '{1, 1,0,'h10,0, 1,0,'h20,0,
                  0,0,0, 0,0,0,0, 0,0, 1};
      tbl[2]  = '{0, 1,1,'h10,'hDEADBEEF, 0,0,0,0,
                  1,0,1, 0,0,0,0, 0,0, 1};
      tbl[3]  = '{0, 1,0,'h10,0, 0,0,0,0,
                  1,0,0, 1,0,0,0, 0,0, 1};
      tbl[4]  = '{0, 0,0,0,0, 0,0,0,0,
                  0,0,0, 1,0,0,0, 'hDEADBEEF,0, 1};
      tbl[5]  = '{0, 0,0,0,0, 1,1,'h3FE,'hAAAA5555,
                  0,1,0, 0,0,0,0, 'hDEADBEEF,0, 1};
      tbl[6]  = '{0, 0,0,0,0, 1,1,'h3F8,'h55,
                  0,1,0, 0,1,0,1, 'hDEADBEEF,0, 1};
      tbl[7]  = '{0, 0,0,0,0, 1,0,'h3F4,0,
                  0,1,0, 0,1,0,1, 'hDEADBEEF,0, 1};
      tbl[8]  = '{0, 1,1,'h20,'h12345678, 0,0,0,0,
                  1,0,1, 0,1,0,0, 'hDEADBEEF,w3f4, 1};
      tbl[9]  = '{0, 0,0,0,0, 1,0,'h20,0,
                  0,1,0, 1,0,0,0, 0,w3f4, 1};
      tbl[10] = '{0, 0,0,0,0, 0,0,0,0,
                  0,0,0, 0,1,0,0, 0,'h12345678, 1};
      tbl[11] = '{0, 1,0,'h10,0, 1,0,'h10,0,
                  0,1,0, 0,0,0,0, 0,'h12345678, 1};
      tbl[12] = '{1, 1,0,'h10,0, 1,0,'h10,0,
                  0,0,0, 0,1,0,0, 0,'hDEADBEEF, 1};
      tbl[13] = '{0, 1,0,'h10,0, 1,0,'h20,0,
                  1,0,0, 0,0,0,0, 0,0, 1};
      tbl[14] = '{0, 1,0,'h20,0, 1,0,'h20,0,
                  1,0,0, 1,0,0,0, 'hDEADBEEF,0, 1};

      for (int i = 0; i < 15; i++) begin
         apply(tbl[i].rst, tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
               tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
         chk($sformatf("row%0d rdy0", i), 32'(r0_ready), 32'(tbl[i].rdy0));
         chk($sformatf("row%0d rdy1", i), 32'(r1_ready), 32'(tbl[i].rdy1));
         chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tbl[i].mwe));
         if (tbl[i].chk) begin
            chk($sformatf("row%0d rv0", i), 32'(r0_rvalid), 32'(tbl[i].rv0));
            chk($sformatf("row%0d rv1", i), 32'(r1_rvalid), 32'(tbl[i].rv1));
            chk($sformatf("row%0d err0", i), 32'(r0_err), 32'(tbl[i].er0));
            chk($sformatf("row%0d err1", i), 32'(r1_err), 32'(tbl[i].er1));
            chk($sformatf("row%0d rd0", i), r0_rdata, tbl[i].rd0);
            chk($sformatf("row%0d rd1", i), r1_rdata, tbl[i].rd1);
         end
      end
      ref_wr('h10, 'hDEADBEEF);
      ref_wr('h20, 'h12345678);

      // Both requesters saturating: bounded bursts alternate owners
      do_reset();
      for (int i = 0; i < 9; i++) begin
         apply(0, 1, 0, 'h40, 0, 1, 0, 'h44, 0);
         chk($sformatf("burst%0d rdy0", i), 32'(r0_ready), 32'(seq[i] == 0));
         chk($sformatf("burst%0d rdy1", i), 32'(r1_ready), 32'(seq[i] == 1));
         if (i > 0) begin
            chk($sformatf("burst%0d rv0", i), 32'(r0_rvalid),
                32'(seq[i-1] == 0));
            chk($sformatf("burst%0d rv1", i), 32'(r1_rvalid),
                32'(seq[i-1] == 1));
         end
      end
      chk("burst rd0", r0_rdata, init_word('h40));
      chk("burst rd1", r1_rdata, init_word('h44));

      // Lone requester keeps the grant; newcomer wins at saturation
      do_reset();
      for (int i = 0; i < 10; i++) begin
         apply(0, 1, 0, 'h8, 0, 0, 0, 0, 0);
         chk($sformatf("solo%0d rdy0", i), 32'(r0_ready), 1);
      end
      apply(0, 1, 0, 'h8, 0, 1, 0, 'hC, 0);
      chk("join rdy1", 32'(r1_ready), 1);
      chk("join rdy0", 32'(r0_ready), 0);
      chk("join rv0", 32'(r0_rvalid), 1);
      chk("join rd0", r0_rdata, init_word('h8));

      // Random traffic against the rule-level model
      do_reset();
      m_owner = 0;
      m_cnt = 0;
      for (int n = 0; n < 2; n++) begin
         pv[n] = 0; pw[n] = 0; pa[n] = 0; pd[n] = 0;
         e_rv[n] = 0; e_er[n] = 0; e_rd[n] = 0;
      end
      for (int c = 0; c < 2000; c++) begin
         rr = ($urandom % 64) == 0;
         for (int n = 0; n < 2; n++)
            if (!pv[n] && ($urandom % 3) != 0) begin
               pv[n] = 1;
               pw[n] = 1'($urandom % 2);
               pa[n] = rand_addr();
               pd[n] = $urandom;
            end
         apply(rr, pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1]);
         chk("rnd rv0", 32'(r0_rvalid), 32'(e_rv[0]));
         chk("rnd rv1", 32'(r1_rvalid), 32'(e_rv[1]));
         chk("rnd err0", 32'(r0_err), 32'(e_er[0]));
         chk("rnd err1", 32'(r1_err), 32'(e_er[1]));
         chk("rnd rd0", r0_rdata, e_rd[0]);
         chk("rnd rd1", r1_rdata, e_rd[1]);
         g = -1;
         if (!rr) begin
            if (pv[m_owner] && (!pv[1-m_owner] || m_cnt < MAXB))
               g = m_owner;
            else if (pv[1-m_owner])
               g = 1 - m_owner;
         end
         ea = (g == 1) ? pa[1] : pa[0];
         ed = (g == 1) ? pd[1] : pd[0];
         lg = (g >= 0) && is_legal(ea);
         chk("rnd rdy0", 32'(r0_ready), 32'(g == 0));
         chk("rnd rdy1", 32'(r1_ready), 32'(g == 1));
         chk("rnd mem_addr", mem_addr, ea);
         chk("rnd mem_wdata", mem_wdata, ed);
         chk("rnd mem_we", 32'(mem_we), 32'(lg && pw[g == 1]));
         if (rr) begin
            m_owner = 0;
            m_cnt = 0;
            for (int n = 0; n < 2; n++) begin
               e_rv[n] = 0; e_er[n] = 0; e_rd[n] = 0;
            end
         end else begin
            for (int n = 0; n < 2; n++) begin
               e_rv[n] = (g == n);
               e_er[n] = (g == n) && !lg;
               if (g == n)
                  e_rd[n] = (lg && !pw[n]) ? ref_word(pa[n]) : 32'd0;
            end
            if (g < 0) begin
               m_cnt = 0;
            end else begin
               if (lg && pw[g])
                  ref_wr(pa[g], pd[g]);
               if (g == m_owner) begin
                  m_cnt = (m_cnt < MAXB) ? m_cnt + 1 : MAXB;
               end else begin
                  m_owner = g;
                  m_cnt = 1;
               end
               pv[g] = 0;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
